// File: rtl/increment_checker.sv
// Receive-side monitor for a free-running modulo-2^WIDTH up-count stream.
// Locks on the first valid word, flags and counts words that break the +1 sequence.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// HUNT   | waiting for a valid word to seed the expected value; no errors
// LOCKED | checking each valid word against expected; drops after a miss run
module increment_checker #(
    parameter int WIDTH       = 2,
    parameter int ERR_W       = 8,
    parameter int LOSS_THRESH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [3:0]       THRESH  = 4'(LOSS_THRESH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] expected_nx;
    logic [WIDTH-1:0] din_inc;
    logic [3:0]       miss_run;
    logic [3:0]       miss_run_nx;
    logic [3:0]       miss_inc;
    logic             err_pulse_nx;
    logic [ERR_W-1:0] err_count_nx;

    // Carry is discarded so all-ones wraps to zero.
    assign din_inc  = din + WIDTH'(1);
    assign miss_inc = miss_run + 4'd1;

    always_comb begin
        state_nx     = state;
        expected_nx  = expected;
        miss_run_nx  = miss_run;
        err_pulse_nx = 1'b0;
        err_count_nx = err_count;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    state_nx    = LOCKED;
                    expected_nx = din_inc;
                    miss_run_nx = 4'd0;
                end
                LOCKED: begin
                    // A mismatching word still resyncs expected to the observed value.
                    expected_nx = din_inc;
                    if (din == expected) begin
                        miss_run_nx = 4'd0;
                    end else begin
                        err_pulse_nx = 1'b1;
                        if (err_count != ERR_MAX)
                            err_count_nx = err_count + ERR_W'(1);
                        if (miss_inc == THRESH) begin
                            state_nx    = HUNT;
                            miss_run_nx = 4'd0;
                        end else begin
                            miss_run_nx = miss_inc;
                        end
                    end
                end
            endcase
        end

        if (clear)
            err_count_nx = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            expected  <= '0;
            miss_run  <= 4'd0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            expected  <= expected_nx;
            miss_run  <= miss_run_nx;
            err_pulse <= err_pulse_nx;
            err_count <= err_count_nx;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_increment_checker.sv
// Bench for increment_checker: two instances (default config, and a small
// saturating counter with a long loss threshold) against a sequence-rule model.
module tb_increment_checker;

    logic       clk;
    logic       reset;
    logic [1:0] din;
    logic       din_valid;
    logic       clear;

    logic       a_locked, a_pulse;
    logic [7:0] a_count;
    logic [1:0] a_exp;
    logic       b_locked, b_pulse;
    logic [1:0] b_count;
    logic [1:0] b_exp;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // model state, index 0 = dut_a, 1 = dut_b
    int m_locked[2];
    int m_exp[2];
    int m_run[2];
    int m_cnt[2];
    int m_pulse[2];
    int thresh[2] = '{3, 15};
    int cmax[2]   = '{255, 3};

    increment_checker dut_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(a_locked), .err_pulse(a_pulse), .err_count(a_count), .expected(a_exp)
    );

    increment_checker #(.WIDTH(2), .ERR_W(2), .LOSS_THRESH(15)) dut_b (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(b_locked), .err_pulse(b_pulse), .err_count(b_count), .expected(b_exp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Sequence-rule model: a valid word is good if it is one more (mod 4)
    // than the last accepted word while locked.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_locked[i] = 0; m_exp[i] = 0; m_run[i] = 0; m_cnt[i] = 0; m_pulse[i] = 0;
            end else begin
                m_pulse[i] = 0;
                if (din_valid) begin
                    if (m_locked[i] == 0) begin
                        m_locked[i] = 1;
                        m_run[i] = 0;
                    end else if (int'(din) == m_exp[i]) begin
                        m_run[i] = 0;
                    end else begin
                        m_pulse[i] = 1;
                        m_cnt[i] = (m_cnt[i] + 1 > cmax[i]) ? cmax[i] : m_cnt[i] + 1;
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == thresh[i]) begin
                            m_locked[i] = 0;
                            m_run[i] = 0;
                        end
                    end
                    m_exp[i] = (int'(din) + 1) % 4;
                end
                if (clear) m_cnt[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_locked",    int'(a_locked), m_locked[0]);
            chk("a_err_pulse", int'(a_pulse),  m_pulse[0]);
            chk("a_err_count", int'(a_count),  m_cnt[0]);
            chk("a_expected",  int'(a_exp),    m_exp[0]);
            chk("b_locked",    int'(b_locked), m_locked[1]);
            chk("b_err_pulse", int'(b_pulse),  m_pulse[1]);
            chk("b_err_count", int'(b_count),  m_cnt[1]);
            chk("b_expected",  int'(b_exp),    m_exp[1]);
        end
    end

    task automatic step(input logic r, input logic v, input logic c, input logic [1:0] d);
        reset = r; din_valid = v; clear = c; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seq [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        reset = 1'b1; din_valid = 1'b0; clear = 1'b0; din = 2'd0;

        step(1, 0, 0, 0);
        chk_en = 1;
        step(1, 0, 0, 0);
        chk("lit_rst_locked", int'(a_locked), 0);
        chk("lit_rst_count",  int'(a_count),  0);
        chk("lit_rst_exp",    int'(a_exp),    0);

        // clean stream
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, seq[i]);
            if (i == 0) chk("lit_clean_lock", int'(a_locked), 1);
        end
        chk("lit_clean_exp",   int'(a_exp),   3);
        chk("lit_clean_count", int'(a_count), 0);

        // single glitch: 3,0,1 in sequence, then 3 where 2 is expected, then 0
        step(0, 1, 0, 3);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 3);
        chk("lit_glitch_pulse", int'(a_pulse), 1);
        chk("lit_glitch_count", int'(a_count), 1);
        step(0, 1, 0, 0);
        chk("lit_glitch_after_pulse", int'(a_pulse),  0);
        chk("lit_glitch_locked",      int'(a_locked), 1);

        // lock loss after three consecutive misses
        step(0, 0, 1, 0);
        step(0, 1, 0, 2);
        step(0, 1, 0, 2);
        step(0, 1, 0, 2);
        chk("lit_loss_locked", int'(a_locked), 0);
        chk("lit_loss_pulse",  int'(a_pulse),  1);
        chk("lit_loss_count",  int'(a_count),  3);
        step(0, 1, 0, 2);
        chk("lit_relock_locked", int'(a_locked), 1);
        chk("lit_relock_pulse",  int'(a_pulse),  0);
        chk("lit_relock_exp",    int'(a_exp),    3);

        // gapped valid
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 3);
        step(0, 1, 0, 1);
        chk("lit_gap_exp",   int'(a_exp),   2);
        chk("lit_gap_count", int'(a_count), 0);
        chk("lit_gap_pulse", int'(a_pulse), 0);

        // saturation and clear on the small counter instance
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("lit_sat_count",  int'(b_count),  3);
        chk("lit_sat_locked", int'(b_locked), 1);
        step(0, 1, 1, 0);
        chk("lit_clr_count", int'(b_count), 0);
        chk("lit_clr_pulse", int'(b_pulse), 1);

        // reset mid-run with err_count=2
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 3);
        step(0, 1, 0, 3);
        chk("lit_pre_rst_count",  int'(a_count),  2);
        chk("lit_pre_rst_locked", int'(a_locked), 1);
        step(1, 1, 1, 3);
        chk("lit_midrst_locked", int'(a_locked), 0);
        chk("lit_midrst_count",  int'(a_count),  0);
        chk("lit_midrst_exp",    int'(a_exp),    0);
        chk("lit_midrst_pulse",  int'(a_pulse),  0);
        step(0, 1, 0, 2);
        chk("lit_midrst_relock", int'(a_locked), 1);
        chk("lit_midrst_nopulse", int'(a_pulse), 0);

        // randomized traffic, mostly in-sequence words
        for (int i = 0; i < 800; i++) begin
            logic       r, v, c;
            logic [1:0] d;
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) < 7) d = 2'(m_exp[0]);
            else                          d = 2'($urandom_range(0, 3));
            step(r, v, c, d);
        end

        @(negedge clk);
        #1;
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/increment_checker.md
# increment_checker

Synthesizable receive-side monitor for a free-running modulo-2^WIDTH up-count stream, such as the 2-bit count clocked through the dflipflop pair. It locks onto the first valid word, checks that every later valid word equals the previous one plus one (with wrap), counts mismatches, and drops lock after a run of consecutive mismatches. It sits after the flip-flop stage and drives LEDs or a lab status display.

## Interface
- WIDTH, 2, bit width of the checked count word
- ERR_W, 8, width of the saturating error counter
- LOSS_THRESH, 3, consecutive mismatches that drop lock (range 1..15)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- din  input  WIDTH  count word under check
- din_valid  input  1  din is sampled on this edge
- clear  input  1  synchronous clear of err_count
- locked  output  1  high while in LOCKED state
- err_pulse  output  1  one-cycle flag for a mismatching sample
- err_count  output  ERR_W  saturating total of mismatches since reset/clear
- expected  output  WIDTH  next value the checker expects

## Operation
- Two states: HUNT and LOCKED. Reset state is HUNT.
- HUNT with din_valid=1:
  - expected <= din+1 (mod 2^WIDTH)
  - go to LOCKED
  - miss_run <= 0
  - no error is possible in HUNT.
- HUNT with din_valid=0: hold all state.
- LOCKED with din_valid=1 and din==expected:
  - expected <= din+1
  - miss_run <= 0
  - err_pulse <= 0
- LOCKED with din_valid=1 and din!=expected:
  - err_pulse <= 1
  - err_count <= err_count+1, saturating at 2^ERR_W-1
  - expected <= din+1, resyncing to the observed value
  - miss_run <= miss_run+1
  - If miss_run+1 == LOSS_THRESH: go to HUNT, miss_run <= 0.
- LOCKED with din_valid=0: hold expected and miss_run; err_pulse <= 0.
- Wrap-around: all-ones followed by zero is a match. The +1 is computed in WIDTH bits with the carry discarded.
- clear:
  - Forces err_count <= 0 and has priority over a simultaneous increment.
  - err_pulse, state, expected and miss_run still update normally on that edge.
- reset mid-operation: all state returns to reset values on the next edge regardless of din_valid or clear.
- Reset values:
  - locked=0, err_pulse=0, err_count=0, expected=0
  - Internal: miss_run=0, state=HUNT.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- A sample is taken on rising edge k when din_valid=1. Its result (err_pulse, err_count, expected, locked) is visible from edge k until edge k+1. Latency is one edge.
- err_pulse is high for exactly one cycle per mismatching sample. Back-to-back mismatches give back-to-back pulses.
- locked rises at the edge that samples the first valid word in HUNT.
- locked falls at the edge that samples the LOSS_THRESH-th consecutive mismatch. err_pulse is also high for that sample.
- The next valid word after lock loss re-locks without raising an error.
- din_valid may be held high continuously (one word per clock) or gapped arbitrarily. Gaps do not affect checking.

## Test plan
- Clean stream, WIDTH=2:
  - Stimulus: reset for 2 cycles, then din_valid=1 with din = 1,2,3,0,1,2 on consecutive edges.
  - Required: locked=1 after the first edge, err_pulse never high, err_count=0, expected=3 at the end.
- Single glitch:
  - Stimulus: locked stream 0,1,3,0.
  - Required: one err_pulse on the sample 3 (expected 2), err_count=1, no error on the following 0, locked stays 1.
- Lock loss, LOSS_THRESH=3:
  - Stimulus: after lock, din held at 2 for four valid edges.
  - Required: three err_pulses; locked falls on the third; err_count=3; the fourth 2 re-locks with no pulse; expected=3.
- Gapped valid:
  - Stimulus: 0, then din_valid=0 for 5 cycles with din=3, then 1.
  - Required: no error, expected=2.
- Saturation and clear, ERR_W=2:
  - Stimulus: force 5 mismatches with LOSS_THRESH=15.
  - Required: err_count sticks at 3. Then clear together with a mismatch gives err_count=0 and err_pulse=1.
- Reset mid-run:
  - Stimulus: assert reset for one edge while locked with err_count=2.
  - Required: next cycle locked=0, err_count=0, expected=0, err_pulse=0; the next valid word re-locks.
